// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-stage RAW hazard stall, control-transfer flush sequencing, stall statistics and watchdog.
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), asynchronous active-low reset
//   i_id_valid, i_id_instr          ID stage instruction and its valid bit
//   i_id_rs1/_used, i_id_rs2/_used  source registers and whether each is read
//   i_ex_*, i_mem_*, i_wb_*         destination register / write enable of later stages (EX also is_load)
//   i_ctrl_done                     control transfer resolved early; ends a flush at the next edge
//   o_pc_write, o_if_id_write       PC and IF/ID update enables
//   o_id_ex_nop, o_if_id_flush      bubble into ID/EX, squash IF/ID
//   o_stall_total, o_stall_err      saturating stall-cycle count, sticky runaway-stall flag
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 3,
    parameter int INSTR_W     = 16,
    parameter int FWD_EN      = 0,
    parameter int WB_BYPASS   = 0,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 200
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_id_valid,
    input  logic [INSTR_W-1:0] i_id_instr,
    input  logic [REG_AW-1:0]  i_id_rs1,
    input  logic               i_id_rs1_used,
    input  logic [REG_AW-1:0]  i_id_rs2,
    input  logic               i_id_rs2_used,
    input  logic [REG_AW-1:0]  i_ex_wr_reg,
    input  logic               i_ex_wr_en,
    input  logic               i_ex_is_load,
    input  logic [REG_AW-1:0]  i_mem_wr_reg,
    input  logic               i_mem_wr_en,
    input  logic [REG_AW-1:0]  i_wb_wr_reg,
    input  logic               i_wb_wr_en,
    input  logic               i_ctrl_done,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_id_ex_nop,
    output logic               o_if_id_flush,
    output logic [CNT_W-1:0]   o_stall_total,
    output logic               o_stall_err
);
    localparam int FW = $clog2(FLUSH_DEPTH + 1);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t            r_state, w_state_nxt;
    logic [FW-1:0]     r_fcnt, w_fcnt_nxt;
    logic [CNT_W-1:0]  r_total, r_scnt;
    logic              r_err;
    logic [4:0]        w_op;
    logic              w_ex_hit, w_mem_hit, w_wb_hit, w_raw, w_ctrl, w_stall;
    assign w_op      = i_id_instr[INSTR_W-1 -: 5];
    assign w_ex_hit  = i_ex_wr_en & ((i_id_rs1_used & (i_ex_wr_reg == i_id_rs1)) |
                                     (i_id_rs2_used & (i_ex_wr_reg == i_id_rs2)));
    assign w_mem_hit = i_mem_wr_en & ((i_id_rs1_used & (i_mem_wr_reg == i_id_rs1)) |
                                      (i_id_rs2_used & (i_mem_wr_reg == i_id_rs2)));
    assign w_wb_hit  = i_wb_wr_en & ((i_id_rs1_used & (i_wb_wr_reg == i_id_rs1)) |
                                     (i_id_rs2_used & (i_wb_wr_reg == i_id_rs2)));
    // With forwarding only a load in EX cannot be bypassed in time.
    assign w_raw     = i_id_valid & ((FWD_EN != 0) ? (w_ex_hit & i_ex_is_load)
                                   : (w_ex_hit | w_mem_hit | ((WB_BYPASS == 0) & w_wb_hit)));
    // Control transfers are opcodes 001xx and 011xx.
    assign w_ctrl    = i_id_valid & ~w_op[4] & w_op[2];
    assign w_stall   = (r_state == RUN) & w_raw;
    assign o_stall_total = r_total;
    assign o_stall_err   = r_err;
    always_comb begin
        w_state_nxt   = r_state;
        w_fcnt_nxt    = r_fcnt;
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_id_ex_nop   = 1'b0;
        o_if_id_flush = 1'b0;
        if (r_state == FLUSH) begin
            o_if_id_flush = 1'b1;
            w_fcnt_nxt    = r_fcnt - 1'b1;
            if (r_fcnt == FW'(1) || i_ctrl_done) w_state_nxt = RUN;
        end else if (w_raw) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_id_ex_nop   = 1'b1;
        end else if (w_ctrl) begin
            o_if_id_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                w_state_nxt = FLUSH;
                w_fcnt_nxt  = FW'(FLUSH_DEPTH - 1);
            end
        end
        // Hazard inputs are live during reset, so force pass-through explicitly.
        if (!i_rst_n) begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            o_id_ex_nop   = 1'b0;
            o_if_id_flush = 1'b0;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_fcnt  <= '0;
            r_total <= '0;
            r_scnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_stall) begin
                if (~&r_total) r_total <= r_total + 1'b1;
                if (r_scnt != CNT_W'(STALL_LIMIT)) r_scnt <= r_scnt + 1'b1;
                if (r_scnt == CNT_W'(STALL_LIMIT - 1)) r_err <= 1'b1;
            end else begin
                r_scnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for two pipe_hazard_ctrl configurations sharing one stimulus stream.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, valid, u1, u2, exen, ld, memen, wben, cdone;
    logic [15:0] instr;
    logic [2:0]  rs1, rs2, exr, memr, wbr;
    logic        a_pc, a_ifid, a_nop, a_fl, a_err, b_pc, b_ifid, b_nop, b_fl, b_err;
    logic [7:0]  a_tot;
    logic [3:0]  b_tot;

    pipe_hazard_ctrl u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(valid), .i_id_instr(instr),
        .i_id_rs1(rs1), .i_id_rs1_used(u1), .i_id_rs2(rs2), .i_id_rs2_used(u2),
        .i_ex_wr_reg(exr), .i_ex_wr_en(exen), .i_ex_is_load(ld),
        .i_mem_wr_reg(memr), .i_mem_wr_en(memen), .i_wb_wr_reg(wbr), .i_wb_wr_en(wben),
        .i_ctrl_done(cdone), .o_pc_write(a_pc), .o_if_id_write(a_ifid), .o_id_ex_nop(a_nop),
        .o_if_id_flush(a_fl), .o_stall_total(a_tot), .o_stall_err(a_err));

    pipe_hazard_ctrl #(.FWD_EN(1), .WB_BYPASS(1), .FLUSH_DEPTH(4), .CNT_W(4), .STALL_LIMIT(10)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(valid), .i_id_instr(instr),
        .i_id_rs1(rs1), .i_id_rs1_used(u1), .i_id_rs2(rs2), .i_id_rs2_used(u2),
        .i_ex_wr_reg(exr), .i_ex_wr_en(exen), .i_ex_is_load(ld),
        .i_mem_wr_reg(memr), .i_mem_wr_en(memen), .i_wb_wr_reg(wbr), .i_wb_wr_en(wben),
        .i_ctrl_done(cdone), .o_pc_write(b_pc), .o_if_id_write(b_ifid), .o_id_ex_nop(b_nop),
        .o_if_id_flush(b_fl), .o_stall_total(b_tot), .o_stall_err(b_err));

    typedef struct packed {
        logic [4:0] o0, o1;
        logic [7:0] t0, t1;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0;

    // Reference configuration per instance: 0 = u_a, 1 = u_b.
    int fwd[2]  = '{0, 1};
    int wbb[2]  = '{0, 1};
    int dep[2]  = '{2, 4};
    int tmax[2] = '{255, 15};
    int lim[2]  = '{200, 10};
    int fl[2], run[2], tot[2];
    bit err[2];

    function automatic bit hit(input logic en, input logic [2:0] wr);
        return en && ((u1 && wr == rs1) || (u2 && wr == rs2));
    endfunction

    // Outputs for the current cycle, then advance state across the coming edge.
    task automatic model(input int k, output logic [4:0] o, output logic [7:0] t);
        bit raw, ctrl;
        raw  = valid && (fwd[k] != 0 ? (hit(exen, exr) && ld)
                                     : (hit(exen, exr) || hit(memen, memr) || (wbb[k] == 0 && hit(wben, wbr))));
        ctrl = valid && (instr[15:11] inside {[5'b00100:5'b00111], [5'b01100:5'b01111]});
        if (!rst_n) begin
            fl[k] = 0; run[k] = 0; tot[k] = 0; err[k] = 0;
            o = 5'b11000;
            t = 8'd0;
            return;
        end
        t = 8'(tot[k]);
        if (fl[k] > 0) begin
            o = {4'b1101, err[k]};
            fl[k] = (cdone || fl[k] == 1) ? 0 : fl[k] - 1;
            run[k] = 0;
        end else if (raw) begin
            o = {4'b0010, err[k]};
            if (tot[k] < tmax[k]) tot[k]++;
            if (run[k] < lim[k]) run[k]++;
            if (run[k] == lim[k]) err[k] = 1;
        end else begin
            o = {3'b110, ctrl, err[k]};
            if (ctrl) fl[k] = dep[k] - 1;
            run[k] = 0;
        end
    endtask

    task automatic step();
        exp_t x;
        model(0, x.o0, x.t0);
        model(1, x.o1, x.t1);
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        valid = 0; instr = 0; u1 = 0; u2 = 0; exen = 0; ld = 0; memen = 0; wben = 0; cdone = 0;
        rs1 = 0; rs2 = 0; exr = 0; memr = 0; wbr = 0;
    endtask

    task automatic rnd();
        valid = ($urandom_range(9) != 0);
        instr = 16'($urandom);
        u1 = 1'($urandom); u2 = 1'($urandom);
        rs1 = 3'($urandom); rs2 = 3'($urandom);
        exr = 3'($urandom); memr = 3'($urandom); wbr = 3'($urandom);
        exen = 1'($urandom); ld = 1'($urandom); memen = 1'($urandom); wben = 1'($urandom);
        cdone = ($urandom_range(4) == 0);
    endtask

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("a_ctl{pc,ifid,nop,flush,err}", int'({a_pc, a_ifid, a_nop, a_fl, a_err}), int'(e.o0));
            chk("a_stall_total", int'(a_tot), int'(e.t0));
            chk("b_ctl{pc,ifid,nop,flush,err}", int'({b_pc, b_ifid, b_nop, b_fl, b_err}), int'(e.o1));
            chk("b_stall_total", int'(b_tot), int'(e.t1));
        end
    end

    localparam logic [15:0] CTRL_I = 16'b01100_00000000000;
    localparam logic [15:0] ALU_I  = 16'b01000_00000000000;

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #2;
        step();
        step();
        rst_n = 1;
        // EX match, non-load: A stalls, B forwards
        idle(); valid = 1; u1 = 1; rs1 = 3; exen = 1; exr = 3; step();
        ld = 1; step();
        exen = 0; step();
        exen = 1; u1 = 0; step();
        // MEM and WB matches
        idle(); valid = 1; u2 = 1; rs2 = 5; memen = 1; memr = 5; step();
        memen = 0; wben = 1; wbr = 5; step();
        valid = 0; step();
        // control transfer, natural flush length
        idle(); valid = 1; instr = CTRL_I; step();
        idle(); repeat (5) step();
        valid = 1; instr = ALU_I; repeat (3) step();
        // early ctrl_done in second flush cycle
        idle(); valid = 1; instr = 16'b00101_00000000000; step();
        idle(); cdone = 1; step();
        cdone = 0; repeat (4) step();
        repeat (400) begin rnd(); step(); end
        // long stall to the watchdog limit, with a stalled control transfer behind it
        rst_n = 0; step();
        rst_n = 1;
        idle(); valid = 1; instr = CTRL_I; u1 = 1; rs1 = 2; exen = 1; exr = 2; ld = 1;
        repeat (205) step();
        exen = 0; step();
        idle(); repeat (6) step();
        // asynchronous reset in the middle of a flush
        idle(); valid = 1; instr = CTRL_I; step();
        idle(); step();
        rst_n = 0; step();
        step();
        rst_n = 1; step();
        step();
        repeat (200) begin rnd(); step(); end
        idle(); step();
        #10;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
